// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU datapath: widths, flag bit positions,
// and the result-stage state and entry types.
package cpu16_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 4;

    // Bit positions inside a {N,Z,C,V} flag nibble
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } rs_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  rd;
        logic [3:0]        flags;
        logic              flag_we;
    } rs_entry_t;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational N/Z/C/V derivation from an adder result. Also intended for
// the shift and logic units, so it depends only on the result and operand MSBs.
module alu_flag_calc
    import cpu16_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic [N-1:0] sum,
    input  logic         co,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic         sub,
    output logic [3:0]   flags
);

    // Overflow: both effective operands share a sign that differs from the result sign.
    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = sum[N-1];
        flags[FLAG_Z] = (sum == '0);
        flags[FLAG_C] = co;  // raw carry; for subtract 1 means no borrow
        flags[FLAG_V] = (a_msb ^ sum[N-1]) & ((b_msb ^ sub) ^ sum[N-1]);
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage behind the N-bit adder. A two-entry skid buffer
// (MAIN drives the outputs, SKID absorbs one extra result) keeps in_ready a
// plain register, and the architectural flag register is updated when a
// flag-writing result retires.
module alu_result_stage
    import cpu16_pkg::*;
#(
    parameter int unsigned N    = DATA_W,  // must equal DATA_W (entry storage width)
    parameter int unsigned RD_W = TAG_W    // must equal TAG_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_sum,
    input  logic            in_co,
    input  logic            in_a_msb,
    input  logic            in_b_msb,
    input  logic            in_sub,
    input  logic            in_flag_we,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic [RD_W-1:0] out_rd,
    output logic [3:0]      out_flags,
    output logic [3:0]      flags_q
);

    rs_state_t state_q, state_d;
    rs_entry_t main_q, main_d;
    rs_entry_t skid_q, skid_d;
    logic [3:0] arch_flags_q, arch_flags_d;

    logic [3:0] in_flags;
    rs_entry_t  in_entry;
    logic       accept;
    logic       retire;

    alu_flag_calc #(
        .N (N)
    ) u_flag_calc (
        .sum   (in_sum),
        .co    (in_co),
        .a_msb (in_a_msb),
        .b_msb (in_b_msb),
        .sub   (in_sub),
        .flags (in_flags)
    );

    // Pack the incoming result into an entry and decode the handshakes.
    always_comb begin
        in_entry.data    = in_sum;
        in_entry.rd      = in_rd;
        in_entry.flags   = in_flags;
        in_entry.flag_we = in_flag_we;
        in_ready         = (state_q != FULL);
        out_valid        = (state_q != EMPTY);
        accept           = in_valid & in_ready;
        retire           = out_valid & out_ready;
    end

    // Next-state logic for the skid buffer and the architectural flags.
    always_comb begin
        state_d      = state_q;
        main_d       = main_q;
        skid_d       = skid_q;
        arch_flags_d = arch_flags_q;

        // A retire still commits its flags even when flush is asserted in the same cycle.
        if (retire && main_q.flag_we) begin
            arch_flags_d = main_q.flags;
        end

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (retire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State, entry and flag registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            arch_flags_q <= 4'b0000;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            arch_flags_q <= arch_flags_d;
        end
    end

    assign out_data  = main_q.data;
    assign out_rd    = main_q.rd;
    assign out_flags = main_q.flags;
    assign flags_q   = arch_flags_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_sum;
    logic        in_co;
    logic        in_a_msb;
    logic        in_b_msb;
    logic        in_sub;
    logic        in_flag_we;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_rd;
    logic [3:0]  out_flags;
    logic [3:0]  flags_q;

    int n_checks;
    int n_errors;

    alu_result_stage #(
        .N    (16),
        .RD_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_co      (in_co),
        .in_a_msb   (in_a_msb),
        .in_b_msb   (in_b_msb),
        .in_sub     (in_sub),
        .in_flag_we (in_flag_we),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_flags  (out_flags),
        .flags_q    (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] sum, input logic co, input logic a, input logic b,
                         input logic sub, input logic we, input logic [3:0] rd);
        in_valid   = 1'b1;
        in_sum     = sum;
        in_co      = co;
        in_a_msb   = a;
        in_b_msb   = b;
        in_sub     = sub;
        in_flag_we = we;
        in_rd      = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        in_sum     = 16'h0;
        in_co      = 1'b0;
        in_a_msb   = 1'b0;
        in_b_msb   = 1'b0;
        in_sub     = 1'b0;
        in_flag_we = 1'b0;
        in_rd      = 4'h0;

        // Reset state
        step();
        step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_data", {16'b0, out_data}, 32'h0);
        check("rst_flags_q", {28'b0, flags_q}, 32'h0);
        #2 rst_n = 1'b1;

        // Test 1: 0x7FFF + 0x0001 = 0x8000, N=1 V=1
        out_ready = 1'b1;
        step();
        drive(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3);
        step();
        idle();
        check("t1_out_valid", {31'b0, out_valid}, 32'd1);
        check("t1_out_data", {16'b0, out_data}, 32'h8000);
        check("t1_out_rd", {28'b0, out_rd}, 32'h3);
        check("t1_out_flags", {28'b0, out_flags}, 32'b1001);
        check("t1_flags_q_pre", {28'b0, flags_q}, 32'h0);
        step();
        check("t1_flags_q", {28'b0, flags_q}, 32'b1001);
        check("t1_drained", {31'b0, out_valid}, 32'd0);

        // Test 2: 5 - 5 = 0, co=1 -> Z,C
        drive(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
        step();
        idle();
        check("t2_out_flags", {28'b0, out_flags}, 32'b0110);
        step();
        check("t2_flags_q", {28'b0, flags_q}, 32'b0110);

        // Test 3: backpressure fills both entries, then drains in order
        out_ready = 1'b0;
        drive(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
        step();
        check("t3_ready_one", {31'b0, in_ready}, 32'd1);
        drive(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        step();
        idle();
        check("t3_ready_full", {31'b0, in_ready}, 32'd0);
        check("t3_hold_data", {16'b0, out_data}, 32'h1111);
        step();
        check("t3_stable_data", {16'b0, out_data}, 32'h1111);
        check("t3_stable_rd", {28'b0, out_rd}, 32'h1);
        out_ready = 1'b1;
        step();
        check("t3_second", {16'b0, out_data}, 32'h2222);
        check("t3_second_rd", {28'b0, out_rd}, 32'h2);
        check("t3_second_valid", {31'b0, out_valid}, 32'd1);
        step();
        check("t3_empty", {31'b0, out_valid}, 32'd0);
        check("t3_flags_kept", {28'b0, flags_q}, 32'b0110);

        // Test 4: streaming 1..8 without bubbles
        for (int i = 1; i <= 8; i++) begin
            drive(16'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(i));
            step();
            check("t4_data", {16'b0, out_data}, 32'(i));
            check("t4_valid", {31'b0, out_valid}, 32'd1);
            check("t4_ready", {31'b0, in_ready}, 32'd1);
        end
        idle();
        step();
        check("t4_drained", {31'b0, out_valid}, 32'd0);

        // Test 5a: flush in FULL with no retire; flags untouched, input dropped
        out_ready = 1'b0;
        drive(16'hAAAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'hA);
        step();
        drive(16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB);
        step();
        check("t5_full", {31'b0, in_ready}, 32'd0);
        check("t5_main_flags", {28'b0, out_flags}, 32'b1010);
        drive(16'hCCCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hC);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("t5a_out_valid", {31'b0, out_valid}, 32'd0);
        check("t5a_in_ready", {31'b0, in_ready}, 32'd1);
        check("t5a_flags_q", {28'b0, flags_q}, 32'b0110);
        step();
        check("t5a_dropped", {31'b0, out_valid}, 32'd0);

        // Test 5b: flush in FULL while MAIN retires; its flags still commit
        drive(16'hAAAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'hA);
        step();
        drive(16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB);
        step();
        idle();
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        check("t5b_out_valid", {31'b0, out_valid}, 32'd0);
        check("t5b_flags_q", {28'b0, flags_q}, 32'b1010);

        // Test 6: asynchronous reset between edges
        out_ready = 1'b0;
        drive(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7);
        step();
        idle();
        check("t6_loaded", {16'b0, out_data}, 32'h1234);
        #2 rst_n = 1'b0;
        #1;
        check("t6_out_valid", {31'b0, out_valid}, 32'd0);
        check("t6_out_data", {16'b0, out_data}, 32'h0);
        check("t6_out_rd", {28'b0, out_rd}, 32'h0);
        check("t6_in_ready", {31'b0, in_ready}, 32'd1);
        check("t6_flags_q", {28'b0, flags_q}, 32'h0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        drive(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3);
        step();
        idle();
        check("t6_post_data", {16'b0, out_data}, 32'h8000);
        check("t6_post_flags", {28'b0, out_flags}, 32'b1001);
        step();
        check("t6_post_flags_q", {28'b0, flags_q}, 32'b1001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
